// File: rtl/timer_pkg.sv
// Shared constants for the bus-attached down-counting timer.
// Register offsets, CTRL/STATUS bit positions and the SoC decode nibble.
package timer_pkg;

   localparam logic [3:0] TIMER_BASE_NIBBLE = 4'h1;

   localparam logic [2:0] TIMER_REG_CTRL     = 3'd0;
   localparam logic [2:0] TIMER_REG_STATUS   = 3'd1;
   localparam logic [2:0] TIMER_REG_PRESCALE = 3'd2;
   localparam logic [2:0] TIMER_REG_RELOAD_L = 3'd3;
   localparam logic [2:0] TIMER_REG_RELOAD_H = 3'd4;
   localparam logic [2:0] TIMER_REG_COUNT_L  = 3'd5;
   localparam logic [2:0] TIMER_REG_COUNT_H  = 3'd6;
   localparam logic [2:0] TIMER_REG_RSVD     = 3'd7;

   localparam int unsigned CTRL_ENABLE_BIT      = 0;
   localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT      = 2;

   localparam int unsigned STATUS_EXPIRED_BIT = 0;
   localparam int unsigned STATUS_RUNNING_BIT = 1;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic enable;
   } timer_ctrl_t;

   function automatic logic [7:0] ctrl_to_byte(input timer_ctrl_t c);
      logic [7:0] b;
      b = '0;
      b[CTRL_ENABLE_BIT]      = c.enable;
      b[CTRL_AUTO_RELOAD_BIT] = c.auto_reload;
      b[CTRL_IRQ_EN_BIT]      = c.irq_en;
      return b;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: fires a one-cycle tick every prescale+1 enabled clocks.
// clear restarts the phase from zero and suppresses the tick for that cycle.
module timer_prescaler (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clear,
   input  logic [7:0] prescale,
   output logic       tick
);

   logic [7:0] presc_cnt_q, presc_cnt_d;

   always_comb begin
      tick        = 1'b0;
      presc_cnt_d = presc_cnt_q;
      if (clear) begin
         presc_cnt_d = '0;
      end else if (enable) begin
         if (presc_cnt_q == prescale) begin
            tick        = 1'b1;
            presc_cnt_d = '0;
         end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt_q <= '0;
      end else begin
         presc_cnt_q <= presc_cnt_d;
      end
   end

endmodule

// File: rtl/timer_periph.sv
// 16-bit down-counting timer with prescaler, sticky expiry flag and interrupt.
// Writes complete in zero wait states; reads insert one wait state.
module timer_periph
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] bus_address,
   input  logic [7:0] bus_data_tx,
   output logic [7:0] bus_data_rx,
   input  logic       bus_read,
   input  logic       bus_write,
   output logic       bus_wait,
   output logic       irq
);

   timer_ctrl_t ctrl_q, ctrl_d;
   logic [7:0]  prescale_q;
   logic [7:0]  reload_l_q, reload_h_q;
   logic [15:0] count_q, count_d;
   logic        expired_q, expired_d;
   logic [7:0]  count_h_shadow_q;
   logic        rd_phase_q;

   logic        wr_ctrl, wr_status, wr_en_bit;
   logic        start, stop, presc_enable, tick;
   logic        rd_start;
   logic [7:0]  rd_data;
   logic [15:0] reload;

   assign reload    = {reload_h_q, reload_l_q};
   assign wr_ctrl   = bus_write && (bus_address == TIMER_REG_CTRL);
   assign wr_status = bus_write && (bus_address == TIMER_REG_STATUS);
   assign wr_en_bit = bus_data_tx[CTRL_ENABLE_BIT];
   assign start     = wr_ctrl && wr_en_bit && !ctrl_q.enable;
   assign stop      = wr_ctrl && !wr_en_bit;
   // A disabling write freezes the count in the same cycle, so no tick may land.
   assign presc_enable = ctrl_q.enable && !stop;

   timer_prescaler u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .enable   (presc_enable),
      .clear    (start),
      .prescale (prescale_q),
      .tick     (tick)
   );

   // Priority order: W1C, then tick (set wins over clear), then CTRL write.
   always_comb begin
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      expired_d = expired_q;

      if (wr_status && bus_data_tx[STATUS_EXPIRED_BIT]) begin
         expired_d = 1'b0;
      end

      if (tick) begin
         if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
         end else begin
            expired_d = 1'b1;
            if (ctrl_q.auto_reload) begin
               count_d = reload;
            end else begin
               ctrl_d.enable = 1'b0;
            end
         end
      end

      if (wr_ctrl) begin
         ctrl_d.enable      = wr_en_bit;
         ctrl_d.auto_reload = bus_data_tx[CTRL_AUTO_RELOAD_BIT];
         ctrl_d.irq_en      = bus_data_tx[CTRL_IRQ_EN_BIT];
         if (start) begin
            count_d = reload;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         prescale_q <= '0;
         reload_l_q <= '0;
         reload_h_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         expired_q <= expired_d;
         if (bus_write) begin
            case (bus_address)
               TIMER_REG_PRESCALE: prescale_q <= bus_data_tx;
               TIMER_REG_RELOAD_L: reload_l_q <= bus_data_tx;
               TIMER_REG_RELOAD_H: reload_h_q <= bus_data_tx;
               default: ;
            endcase
         end
      end
   end

   // Read handshake: first cycle of an access stalls and captures.
   assign rd_start = bus_read && !rd_phase_q;
   assign bus_wait = rd_start;
   assign irq      = expired_q && ctrl_q.irq_en;

   always_comb begin
      rd_data = '0;
      case (bus_address)
         TIMER_REG_CTRL:     rd_data = ctrl_to_byte(ctrl_q);
         TIMER_REG_STATUS: begin
            rd_data[STATUS_EXPIRED_BIT] = expired_q;
            rd_data[STATUS_RUNNING_BIT] = ctrl_q.enable;
         end
         TIMER_REG_PRESCALE: rd_data = prescale_q;
         TIMER_REG_RELOAD_L: rd_data = reload_l_q;
         TIMER_REG_RELOAD_H: rd_data = reload_h_q;
         TIMER_REG_COUNT_L:  rd_data = count_q[7:0];
         TIMER_REG_COUNT_H:  rd_data = count_h_shadow_q;
         default:            rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_data_rx      <= '0;
         count_h_shadow_q <= '0;
         rd_phase_q       <= 1'b0;
      end else begin
         rd_phase_q <= bus_read;
         if (rd_start) begin
            bus_data_rx <= rd_data;
            // Latching the high byte here makes a COUNT_L/COUNT_H pair coherent.
            if (bus_address == TIMER_REG_COUNT_L) begin
               count_h_shadow_q <= count_q[15:8];
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: register table plus timed scenarios.
// Read expectations pass through a scoreboard queue between issue and capture.
module tb_timer_periph;
   import timer_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] bus_address;
   logic [7:0] bus_data_tx;
   logic [7:0] bus_data_rx;
   logic       bus_read;
   logic       bus_write;
   logic       bus_wait;
   logic       irq;

   int n_tests;
   int n_fail;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[16];

   timer_periph dut (
      .clk         (clk),
      .rst         (rst),
      .bus_address (bus_address),
      .bus_data_tx (bus_data_tx),
      .bus_data_rx (bus_data_rx),
      .bus_read    (bus_read),
      .bus_write   (bus_write),
      .bus_wait    (bus_wait),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // All bus tasks start and end at a falling edge.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
      bus_address = a;
      bus_data_tx = d;
      bus_write   = 1'b1;
      @(negedge clk);
      bus_write   = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string name);
      logic [7:0] e;
      bus_address = a;
      bus_read    = 1'b1;
      exp_q.push_back(exp);
      #1 check({name, "_wait1"}, int'(bus_wait), 1);
      @(negedge clk);
      check({name, "_wait2"}, int'(bus_wait), 0);
      e = exp_q.pop_front();
      check(name, int'(bus_data_rx), int'(e));
      bus_read = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus_address = '0;
      bus_data_tx = '0;
      bus_read    = 1'b0;
      bus_write   = 1'b0;

      vecs[0]  = '{1'b0, TIMER_REG_CTRL,     8'h00, 8'h00};
      vecs[1]  = '{1'b0, TIMER_REG_STATUS,   8'h00, 8'h00};
      vecs[2]  = '{1'b0, TIMER_REG_COUNT_L,  8'h00, 8'h00};
      vecs[3]  = '{1'b0, TIMER_REG_RSVD,     8'h00, 8'h00};
      vecs[4]  = '{1'b1, TIMER_REG_PRESCALE, 8'hA5, 8'h00};
      vecs[5]  = '{1'b0, TIMER_REG_PRESCALE, 8'h00, 8'hA5};
      vecs[6]  = '{1'b1, TIMER_REG_RELOAD_L, 8'h3C, 8'h00};
      vecs[7]  = '{1'b0, TIMER_REG_RELOAD_L, 8'h00, 8'h3C};
      vecs[8]  = '{1'b1, TIMER_REG_RELOAD_H, 8'hC3, 8'h00};
      vecs[9]  = '{1'b0, TIMER_REG_RELOAD_H, 8'h00, 8'hC3};
      vecs[10] = '{1'b1, TIMER_REG_CTRL,     8'hFE, 8'h00};
      vecs[11] = '{1'b0, TIMER_REG_CTRL,     8'h00, 8'h06};
      vecs[12] = '{1'b1, TIMER_REG_RSVD,     8'hFF, 8'h00};
      vecs[13] = '{1'b0, TIMER_REG_RSVD,     8'h00, 8'h00};
      vecs[14] = '{1'b1, TIMER_REG_CTRL,     8'h00, 8'h00};
      vecs[15] = '{1'b0, TIMER_REG_STATUS,   8'h00, 8'h00};

      idle(2);
      rst = 1'b0;
      idle(1);
      check("reset_irq", int'(irq), 0);
      check("reset_wait", int'(bus_wait), 0);
      check("reset_rx", int'(bus_data_rx), 0);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
         else bus_rd(vecs[i].addr, vecs[i].exp, $sformatf("table%0d", i));
      end

      // One-shot: expiry exactly 4 clocks after the enabling edge.
      bus_wr(TIMER_REG_PRESCALE, 8'h00);
      bus_wr(TIMER_REG_RELOAD_L, 8'h03);
      bus_wr(TIMER_REG_RELOAD_H, 8'h00);
      bus_wr(TIMER_REG_CTRL, 8'h05);
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         check($sformatf("oneshot_early%0d", i), int'(irq), 0);
      end
      idle(1);
      check("oneshot_irq", int'(irq), 1);
      bus_rd(TIMER_REG_STATUS, 8'h01, "oneshot_status");
      bus_rd(TIMER_REG_COUNT_L, 8'h00, "oneshot_count");
      idle(5);
      bus_rd(TIMER_REG_COUNT_L, 8'h00, "oneshot_count_hold");
      bus_rd(TIMER_REG_CTRL, 8'h04, "oneshot_ctrl");

      // Auto-reload: count 1,0,1,0 sampled every 3 clocks; expiry every 6.
      bus_wr(TIMER_REG_STATUS, 8'h01);
      bus_wr(TIMER_REG_PRESCALE, 8'h02);
      bus_wr(TIMER_REG_RELOAD_L, 8'h01);
      bus_wr(TIMER_REG_CTRL, 8'h03);
      bus_rd(TIMER_REG_COUNT_L, 8'h01, "auto_c0");
      idle(1);
      bus_rd(TIMER_REG_COUNT_L, 8'h00, "auto_c1");
      idle(1);
      bus_rd(TIMER_REG_COUNT_L, 8'h01, "auto_c2");
      idle(1);
      bus_rd(TIMER_REG_COUNT_L, 8'h00, "auto_c3");
      idle(1);
      bus_rd(TIMER_REG_STATUS, 8'h03, "auto_status");
      bus_wr(TIMER_REG_STATUS, 8'h01);
      idle(2);
      bus_rd(TIMER_REG_STATUS, 8'h02, "auto_before_exp");
      bus_rd(TIMER_REG_STATUS, 8'h03, "auto_after_exp");
      bus_wr(TIMER_REG_CTRL, 8'h00);

      // Atomic 16-bit read through the COUNT_H shadow.
      bus_wr(TIMER_REG_PRESCALE, 8'h00);
      bus_wr(TIMER_REG_RELOAD_L, 8'h00);
      bus_wr(TIMER_REG_RELOAD_H, 8'h01);
      bus_wr(TIMER_REG_CTRL, 8'h01);
      bus_rd(TIMER_REG_COUNT_L, 8'h00, "atomic_lo");
      bus_rd(TIMER_REG_COUNT_H, 8'h01, "atomic_hi");
      bus_rd(TIMER_REG_COUNT_L, 8'hFC, "atomic_lo2");
      bus_rd(TIMER_REG_COUNT_H, 8'h00, "atomic_hi2");
      bus_wr(TIMER_REG_CTRL, 8'h00);

      // W1C landing on the expiry edge: set wins.
      bus_wr(TIMER_REG_STATUS, 8'h01);
      bus_wr(TIMER_REG_RELOAD_L, 8'h03);
      bus_wr(TIMER_REG_RELOAD_H, 8'h00);
      bus_wr(TIMER_REG_CTRL, 8'h05);
      idle(3);
      check("w1c_pre_irq", int'(irq), 0);
      bus_wr(TIMER_REG_STATUS, 8'h01);
      check("w1c_race_irq", int'(irq), 1);
      bus_rd(TIMER_REG_STATUS, 8'h01, "w1c_race_status");
      bus_wr(TIMER_REG_STATUS, 8'h01);
      check("w1c_clear_irq", int'(irq), 0);

      // Disable at count 5 freezes; re-enable reloads.
      bus_wr(TIMER_REG_RELOAD_L, 8'h10);
      bus_wr(TIMER_REG_CTRL, 8'h01);
      idle(11);
      bus_wr(TIMER_REG_CTRL, 8'h00);
      idle(20);
      bus_rd(TIMER_REG_COUNT_L, 8'h05, "dis_count_lo");
      bus_rd(TIMER_REG_COUNT_H, 8'h00, "dis_count_hi");
      bus_rd(TIMER_REG_STATUS, 8'h00, "dis_status");
      bus_wr(TIMER_REG_CTRL, 8'h01);
      bus_rd(TIMER_REG_COUNT_L, 8'h10, "dis_reload");
      bus_wr(TIMER_REG_CTRL, 8'h00);

      // Reset asserted mid-operation and mid-read.
      bus_wr(TIMER_REG_PRESCALE, 8'h03);
      bus_wr(TIMER_REG_RELOAD_L, 8'h00);
      bus_wr(TIMER_REG_CTRL, 8'h05);
      idle(6);
      check("rst_pre_irq", int'(irq), 1);
      bus_rd(TIMER_REG_CTRL, 8'h04, "rst_pre_ctrl");
      bus_address = TIMER_REG_PRESCALE;
      bus_read    = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_async_irq", int'(irq), 0);
      check("rst_async_rx", int'(bus_data_rx), 0);
      bus_read = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(1);
      for (int a = 0; a < 8; a++) begin
         bus_rd(3'(a), 8'h00, $sformatf("rst_reg%0d", a));
      end
      check("rst_post_irq", int'(irq), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_periph.md
# timer_periph

Bus-attached 16-bit down-counting timer for the register space at 0xFF10–0xFF17, beside uart0 (0xFF00–0xFF0F).
- The SoC decoder gates `bus_read`/`bus_write` with `bus_address_out[7:4] == 4'h1` and routes `bus_data_rx`/`bus_wait` back through its register-space mux.
- An 8-bit prescaler paces the counter; expiry sets a sticky flag and drives an interrupt line for the CPU.

## Interface
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high. Single clock domain throughout.
- `bus_address` in 3: register offset (`bus_address_out[2:0]`).
- `bus_data_tx` in 8: write data.
- `bus_data_rx` out 8: registered read data. Reset value 0x00.
- `bus_read` in 1: read strobe, pre-gated by decoder.
- `bus_write` in 1: write strobe, pre-gated by decoder.
- `bus_wait` out 1: stall request to CPU. Reset value 0.
- `irq` out 1: `expired & CTRL.irq_en`. Reset value 0.

## Operation
Register map, by offset:
- 0 CTRL, R/W:
  - bit0 `enable`
  - bit1 `auto_reload`
  - bit2 `irq_en`
  - bits 7:3 read 0
- 1 STATUS:
  - bit0 `expired`, W1C
  - bit1 `running`, RO, equals `enable`
- 2 PRESCALE, R/W: tick every PRESCALE+1 clocks.
- 3 RELOAD_L, R/W.
- 4 RELOAD_H, R/W.
- 5 COUNT_L, RO. The read capture also latches `count[15:8]` into `count_h_shadow`.
- 6 COUNT_H, RO: returns `count_h_shadow`.
- 7 reserved: reads 0x00, writes ignored.

Counting:
- A write to CTRL that moves `enable` from 0 to 1 loads `count <= reload` and clears `presc_cnt`.
- While enabled, `presc_cnt` increments. When `presc_cnt == PRESCALE`, it returns to 0 and a one-cycle `tick` fires.
- On `tick` with `count != 0`: `count <= count - 1`.
- On `tick` with `count == 0`:
  - `expired <= 1`.
  - If `auto_reload`: `count <= reload`.
  - Else: `enable <= 0` and `count` stays 0.
- Period is therefore (reload+1)·(PRESCALE+1) clocks. reload = 0 expires on every tick.
- No wrap-around: `count` never decrements below 0.

Updates while running:
- A write to PRESCALE takes effect at the next `presc_cnt` comparison.
- A write to RELOAD affects only the next load.
- A write to CTRL with `enable` = 0 stops counting immediately and freezes `count`.

## Timing
Writes:
- Zero wait states: `bus_wait` stays 0.
- The register updates at the clock edge where `bus_write` is high.

Reads have one wait state, controlled by the `rd_phase` flop:
- **Cycle 1** (`bus_read` = 1, `rd_phase` = 0): `bus_wait` = 1 (combinational). `bus_data_rx` captures the addressed register. Side effects occur here. `rd_phase <= 1`.
- **Cycle 2+** (`rd_phase` = 1): `bus_wait` = 0 and data is valid. `rd_phase` clears the cycle after `bus_read` falls.
- Read side effects (COUNT_L shadow latch) occur exactly once per access, even if `bus_read` is held.

Simultaneous events:
- Expiry and a W1C of `expired` in the same cycle: set wins, and `expired` stays 1.
- A CTRL write (0→1 `enable`) and a tick in the same cycle: the CTRL write wins, and `count` loads `reload`.
- A one-shot expiry and a CTRL write with `enable` = 1 in the same cycle: the write wins, and the timer stays enabled.

Reset:
- Reset clears all registers, `presc_cnt`, `count`, `count_h_shadow`, `rd_phase` and `expired`, including when asserted mid-count or mid-read.
- Outputs return to reset values asynchronously.

## Structure
- Shared package `timer_pkg`:
  - register offset constants `TIMER_REG_CTRL` … `TIMER_REG_COUNT_H`
  - CTRL bit indices
  - STATUS bit indices
  - base-address nibble `TIMER_BASE_NIBBLE = 4'h1` for the SoC decoder
- One sub-module, `timer_prescaler`: inputs `enable`, `clear`, `prescale[7:0]`; output `tick`.
- The counter, register file and bus handshake live in `timer_periph`.

## Test plan
- **Reset:** assert `rst` mid-operation, then read all offsets → CTRL/STATUS/PRESCALE/RELOAD/COUNT read 0x00; `irq` = 0; the first read cycle shows `bus_wait` = 1 and the second shows 0.
- **One-shot:**
  - Setup: PRESCALE = 0, RELOAD = 0x0003, CTRL = 0x05.
  - Response: `expired` and `irq` rise exactly 4 clocks after the enabling write edge; STATUS then reads 0x01; `count` stays 0.
- **Auto-reload:**
  - Setup: PRESCALE = 2, RELOAD = 0x0001, CTRL = 0x03.
  - Response: expiry ticks every 6 clocks; `count` sequence is 1, 0, 1, 0; STATUS.running stays 1.
- **Atomic 16-bit read:**
  - Setup: RELOAD = 0x0100, PRESCALE = 0, enable.
  - Response: reading COUNT_L while the count is 0x0100 and COUNT_H after a rollover returns 0x00/0x01, i.e. the shadow captured at the COUNT_L read.
- **W1C race:**
  - Stimulus: write 0x01 to STATUS in the same cycle as an expiry tick.
  - Response: `expired` stays 1; a later W1C with no tick clears it and drops `irq`.
- **Disable mid-count:**
  - Stimulus: write CTRL = 0x00 at count 0x0005.
  - Response: count freezes at 0x0005 and there is no expiry.
  - Then write CTRL = 0x01: count reloads from RELOAD, not from 0x0005.
